ir_receiver_nec: RTL and testbench
==================================

// Module: ir_receiver_nec
// PURPOSE
//  NEC IR frame decoder; receive-side counterpart of the team's NEC transmitter.
//  Takes the demodulated output of an IR receiver (idle high, low = carrier burst)
//  and times marks/spaces at 50 MHz. Recovers the 32-bit frame (LSB first), checks
//  the inverted address/command bytes, and presents addr/cmd with a 1-cycle strobe.
// PARAMETERS  (all counts in clk cycles @ 50 MHz)
//  LEAD_MARK_MIN   400000  min leader mark (8 ms)
//  LEAD_MARK_MAX   500000  max leader mark (10 ms)
//  LEAD_SPACE_MIN  200000  min leader space (4 ms)
//  LEAD_SPACE_MAX  250000  max leader space (5 ms)
//  REP_SPACE_MIN   100000  min repeat space (2 ms), used only with IR_RX_REPEAT_EN
//  REP_SPACE_MAX   125000  max repeat space (2.5 ms), used only with IR_RX_REPEAT_EN
//  BIT_MARK_MAX    40000   max bit/stop mark (0.8 ms)
//  SPACE_THRESH    56250   bit space < thresh -> 0, >= thresh -> 1 (1.125 ms)
//  SPACE_MAX       100000  bit space timeout (2 ms)
// PORTS
//  clk        in   1   50 MHz system clock
//  rst_n      in   1   synchronous reset, active low
//  ir_in      in   1   demodulated IR, async; 0 = mark (carrier), 1 = space
//  valid      out  1   1-cycle strobe: good frame, addr/cmd/data updated
//  err        out  1   1-cycle strobe: timing or checksum violation
//  repeat_out out  1   1-cycle strobe: NEC repeat frame (macro only, else 0)
//  addr       out  8   last good address, held until next good frame
//  cmd        out  8   last good command, held until next good frame
//  data       out  32  last good raw frame {~cmd,cmd,~addr,addr}
//  busy       out  1   1 while FSM is not in IDLE
//  rx_status  out  4   current FSM state code (debug)
// BEHAVIOUR
//  - Reset synchronous, active low: all outputs 0, FSM IDLE, counters 0, sync FFs 1.
//  - ir_in passes a 2-FF synchronizer plus 1 delay FF; edges are detected on the
//    synchronized signal. Duration counter is 20 bits, saturating, cleared at every edge.
//  - States (rx_status): IDLE=0 LEAD_MARK=1 LEAD_SPACE=2 BIT_MARK=3 BIT_SPACE=4
//    REP_STOP=5 WAIT_HIGH=6.
//  - IDLE: falling edge -> LEAD_MARK.
//  - LEAD_MARK: rising edge with cnt>=LEAD_MARK_MIN -> LEAD_SPACE. Rising edge with
//    shorter cnt -> IDLE silently (glitch, no err). cnt>LEAD_MARK_MAX -> err, WAIT_HIGH.
//  - LEAD_SPACE: falling edge with cnt in [LEAD_SPACE_MIN,LEAD_SPACE_MAX] -> BIT_MARK,
//    bit_cnt=0. Repeat window (macro only) -> REP_STOP. Any other value, or
//    cnt>LEAD_SPACE_MAX while high -> err, IDLE.
//  - BIT_MARK: rising edge with cnt<=BIT_MARK_MAX: bit_cnt==32 -> frame check, IDLE;
//    else -> BIT_SPACE. cnt>BIT_MARK_MAX -> err, WAIT_HIGH.
//  - BIT_SPACE: falling edge -> shreg<={bit,shreg[31:1]} (LSB first), bit_cnt+1,
//    -> BIT_MARK. cnt>SPACE_MAX -> err, IDLE.
//  - Frame check: shreg[15:8]==~shreg[7:0] and shreg[31:24]==~shreg[23:16] -> load
//    data/addr/cmd, pulse valid. Otherwise pulse err; data/addr/cmd unchanged.
//  - WAIT_HIGH: hold until synchronized input is 1, then IDLE. This prevents decoding
//    a partial mark as a leader.
//  - Latency: valid/err/repeat_out rise 4 clk after the ir_in rising edge that ends the
//    stop mark, high exactly 1 cycle. valid and err are never high together.
//  - Reset mid-frame aborts the frame with no strobe. The next leader decodes normally.
// CONFIGURATION
//  IR_RX_REPEAT_EN defined:
//   - LEAD_SPACE accepts [REP_SPACE_MIN,REP_SPACE_MAX] -> REP_STOP.
//   - REP_STOP: rising edge with cnt<=BIT_MARK_MAX pulses repeat_out, -> IDLE;
//     addr/cmd held. Overlong mark -> err, WAIT_HIGH.
//   - repeat_out is suppressed (err instead) if no good frame was received since reset.
//  IR_RX_REPEAT_EN undefined:
//   - repeat_out tied 0, REP_STOP absent.
//   - A 2.25 ms leader space is a timing error (err pulse).
// TESTING
//  1 Envelope with NEC transmitter timing, addr=0x5A cmd=0x3C -> one valid,
//    addr=5A cmd=3C data=C33CA55A, err=0.
//  2 Same frame, bit 16 flipped (cmd byte 0x3D) -> err 1 cycle, no valid,
//    addr/cmd keep previous value.
//  3 1 ms low glitch then 30 ms high -> no valid, no err, busy back to 0.
//  4 Good frame, then 9 ms mark + 2.25 ms space + 560 us mark -> macro on: repeat_out
//    1 cycle, addr unchanged; macro off: err 1 cycle.
//  5 rst_n low for 1 cycle after 16 bits -> all outputs 0 next edge; following frame
//    addr=0x01 cmd=0xFE -> valid, data=01FEFE01.
//  6 Bit space held 3 ms -> err, rx_status returns to 0.

Source files
------------

// File: rtl/ir_receiver_nec_if.sv
// Decoded-frame side of the NEC IR receiver: strobes, held frame fields, status.
// The decoder drives the master modport; consumers attach to the slave modport.
interface ir_receiver_nec_if;
   logic        valid;
   logic        err;
   logic        repeat_out;
   logic [7:0]  addr;
   logic [7:0]  cmd;
   logic [31:0] data;
   logic        busy;
   logic [3:0]  rx_status;

   modport master (output valid, err, repeat_out, addr, cmd, data, busy, rx_status);
   modport slave  (input  valid, err, repeat_out, addr, cmd, data, busy, rx_status);
endinterface

// File: rtl/ir_receiver_nec.sv
// NEC IR frame decoder: times marks/spaces on demodulated IR and emits addr/cmd strobes.
// Define IR_RX_REPEAT_EN to decode NEC repeat frames onto repeat_out.
module ir_receiver_nec #(
   parameter int LEAD_MARK_MIN  = 400000,
   parameter int LEAD_MARK_MAX  = 500000,
   parameter int LEAD_SPACE_MIN = 200000,
   parameter int LEAD_SPACE_MAX = 250000,
   parameter int REP_SPACE_MIN  = 100000,
   parameter int REP_SPACE_MAX  = 125000,
   parameter int BIT_MARK_MAX   = 40000,
   parameter int SPACE_THRESH   = 56250,
   parameter int SPACE_MAX      = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ir_in,
   ir_receiver_nec_if.master rx
);
   localparam logic [19:0] LM_MIN = 20'(LEAD_MARK_MIN);
   localparam logic [19:0] LM_MAX = 20'(LEAD_MARK_MAX);
   localparam logic [19:0] LS_MIN = 20'(LEAD_SPACE_MIN);
   localparam logic [19:0] LS_MAX = 20'(LEAD_SPACE_MAX);
   localparam logic [19:0] RS_MIN = 20'(REP_SPACE_MIN);
   localparam logic [19:0] RS_MAX = 20'(REP_SPACE_MAX);
   localparam logic [19:0] BM_MAX = 20'(BIT_MARK_MAX);
   localparam logic [19:0] SP_TH  = 20'(SPACE_THRESH);
   localparam logic [19:0] SP_MAX = 20'(SPACE_MAX);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LEAD_MARK  = 3'd1,
      LEAD_SPACE = 3'd2,
      BIT_MARK   = 3'd3,
      BIT_SPACE  = 3'd4,
      REP_STOP   = 3'd5,
      WAIT_HIGH  = 3'd6
   } state_t;

   state_t      state;
   logic [1:0]  sync;
   logic        dly, rise, fall;
   logic [19:0] cnt;
   logic [5:0]  bit_cnt;
   logic [31:0] shreg;
   logic        valid_r, err_r;
   logic [7:0]  addr_r, cmd_r;
   logic [31:0] data_r;
   logic        lead_win, rep_win;

   // Edge strobes are registered, so the FSM sees each edge 3 clk after ir_in moves.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= 2'b11;
         dly  <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
         cnt  <= '0;
      end else begin
         sync <= {sync[0], ir_in};
         dly  <= sync[1];
         rise <= sync[1] & ~dly;
         fall <= ~sync[1] & dly;
         if (rise | fall)      cnt <= '0;
         else if (cnt != '1)   cnt <= cnt + 20'd1;
      end
   end

   assign lead_win = (cnt >= LS_MIN) && (cnt <= LS_MAX);
   assign rep_win  = (cnt >= RS_MIN) && (cnt <= RS_MAX);

`ifdef IR_RX_REPEAT_EN
   logic rep_r, have_frame;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         addr_r  <= '0;
         cmd_r   <= '0;
         data_r  <= '0;
`ifdef IR_RX_REPEAT_EN
         rep_r      <= 1'b0;
         have_frame <= 1'b0;
`endif
      end else begin
         valid_r <= 1'b0;
         err_r   <= 1'b0;
`ifdef IR_RX_REPEAT_EN
         rep_r   <= 1'b0;
`endif
         case (state)
            IDLE: if (fall) state <= LEAD_MARK;
            // A too-short leader mark is treated as noise and dropped silently.
            LEAD_MARK:
               if (rise)               state <= (cnt >= LM_MIN) ? LEAD_SPACE : IDLE;
               else if (cnt > LM_MAX) begin err_r <= 1'b1; state <= WAIT_HIGH; end
            LEAD_SPACE:
               if (fall) begin
                  if (lead_win) begin
                     state   <= BIT_MARK;
                     bit_cnt <= '0;
                  end else if (rep_win) begin
`ifdef IR_RX_REPEAT_EN
                     state <= REP_STOP;
`else
                     err_r <= 1'b1;
                     state <= IDLE;
`endif
                  end else begin
                     err_r <= 1'b1;
                     state <= IDLE;
                  end
               end else if (cnt > LS_MAX) begin
                  err_r <= 1'b1;
                  state <= IDLE;
               end
            BIT_MARK:
               if (cnt > BM_MAX) begin
                  err_r <= 1'b1;
                  state <= WAIT_HIGH;
               end else if (rise) begin
                  if (bit_cnt == 6'd32) begin
                     state <= IDLE;
                     if (shreg[15:8] == ~shreg[7:0] && shreg[31:24] == ~shreg[23:16]) begin
                        valid_r <= 1'b1;
                        data_r  <= shreg;
                        addr_r  <= shreg[7:0];
                        cmd_r   <= shreg[23:16];
`ifdef IR_RX_REPEAT_EN
                        have_frame <= 1'b1;
`endif
                     end else begin
                        err_r <= 1'b1;
                     end
                  end else begin
                     state <= BIT_SPACE;
                  end
               end
            BIT_SPACE:
               if (fall) begin
                  shreg   <= {cnt >= SP_TH, shreg[31:1]};
                  bit_cnt <= bit_cnt + 6'd1;
                  state   <= BIT_MARK;
               end else if (cnt > SP_MAX) begin
                  err_r <= 1'b1;
                  state <= IDLE;
               end
`ifdef IR_RX_REPEAT_EN
            REP_STOP:
               if (cnt > BM_MAX) begin
                  err_r <= 1'b1;
                  state <= WAIT_HIGH;
               end else if (rise) begin
                  rep_r <= have_frame;
                  err_r <= ~have_frame;
                  state <= IDLE;
               end
`endif
            WAIT_HIGH: if (sync[1]) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   assign rx.valid     = valid_r;
   assign rx.err       = err_r;
   assign rx.addr      = addr_r;
   assign rx.cmd       = cmd_r;
   assign rx.data      = data_r;
   assign rx.busy      = (state != IDLE);
   assign rx.rx_status = {1'b0, state};
`ifdef IR_RX_REPEAT_EN
   assign rx.repeat_out = rep_r;
`else
   assign rx.repeat_out = 1'b0;
`endif
endmodule

// File: tb/tb_ir_receiver_nec.sv
// Directed + randomized bench for ir_receiver_nec with timings scaled down 1000x.
// Expected frame outcomes come from the NEC byte/inverse rules applied to each sent word.
module tb_ir_receiver_nec;
   localparam int LM_MIN = 400, LM_MAX = 500, LS_MIN = 200, LS_MAX = 250;
   localparam int RS_MIN = 100, RS_MAX = 125, BM_MAX = 40, TH = 56, SP_MAX = 100;

   logic clk = 1'b0, rst_n = 1'b0, ir_in = 1'b1;
   int checks = 0, errors = 0;
   int n_valid = 0, n_err = 0, n_rep = 0;
   logic bad_overlap = 1'b0, bad_width = 1'b0;
   logic pv = 1'b0, pe = 1'b0, pr = 1'b0;
   logic [7:0]  exp_addr = '0, exp_cmd = '0;
   logic [31:0] exp_data = '0;

   ir_receiver_nec_if rx_if();

   ir_receiver_nec #(
      .LEAD_MARK_MIN(LM_MIN), .LEAD_MARK_MAX(LM_MAX),
      .LEAD_SPACE_MIN(LS_MIN), .LEAD_SPACE_MAX(LS_MAX),
      .REP_SPACE_MIN(RS_MIN), .REP_SPACE_MAX(RS_MAX),
      .BIT_MARK_MAX(BM_MAX), .SPACE_THRESH(TH), .SPACE_MAX(SP_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .rx(rx_if)
   );

   always #10 clk = ~clk;

   // Strobe monitor: counts pulses and flags overlap or pulses wider than one cycle.
   always @(negedge clk) begin
      if (rx_if.valid === 1'b1) n_valid++;
      if (rx_if.err === 1'b1) n_err++;
      if (rx_if.repeat_out === 1'b1) n_rep++;
      if (rx_if.valid === 1'b1 && rx_if.err === 1'b1) bad_overlap = 1'b1;
      if ((rx_if.valid === 1'b1 && pv) || (rx_if.err === 1'b1 && pe) ||
          (rx_if.repeat_out === 1'b1 && pr)) bad_width = 1'b1;
      pv = (rx_if.valid === 1'b1);
      pe = (rx_if.err === 1'b1);
      pr = (rx_if.repeat_out === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      ir_in = v;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] nec_word(input logic [7:0] a, input logic [7:0] c);
      return {~c, c, ~a, a};
   endfunction

   // Leader plus the first nbits data bits, LSB first, with jittered NEC timing.
   task automatic send_bits(input logic [31:0] w, input int nbits);
      hold(1'b0, $urandom_range(430, 470));
      hold(1'b1, $urandom_range(212, 238));
      for (int i = 0; i < nbits; i++) begin
         hold(1'b0, $urandom_range(22, 34));
         hold(1'b1, w[i] ? $urandom_range(75, 95) : $urandom_range(22, 34));
      end
   endtask

   task automatic send_frame(input logic [31:0] w);
      send_bits(w, 32);
      hold(1'b0, $urandom_range(22, 34));
      ir_in = 1'b1;
   endtask

   task automatic send_repeat();
      hold(1'b0, $urandom_range(430, 470));
      hold(1'b1, $urandom_range(108, 116));
      hold(1'b0, $urandom_range(22, 34));
      ir_in = 1'b1;
   endtask

   // Sends a full frame and checks strobes and held fields against the byte-inverse rule.
   task automatic frame_test(input string tag, input logic [31:0] w);
      int v0, e0;
      logic good;
      v0 = n_valid; e0 = n_err;
      send_frame(w);
      hold(1'b1, 300);
      good = ((w[7:0] ^ w[15:8]) == 8'hFF) && ((w[23:16] ^ w[31:24]) == 8'hFF);
      if (good) begin
         exp_addr = w[7:0];
         exp_cmd  = w[23:16];
         exp_data = w;
      end
      chk({tag, "_valid"}, n_valid - v0, good ? 1 : 0);
      chk({tag, "_err"},   n_err - e0,   good ? 0 : 1);
      chk({tag, "_addr"},  rx_if.addr, exp_addr);
      chk({tag, "_cmd"},   rx_if.cmd,  exp_cmd);
      chk({tag, "_data"},  rx_if.data, exp_data);
      chk({tag, "_state"}, rx_if.rx_status, 0);
   endtask

   initial begin
      int v0, e0, r0;
      logic [5:0]  lat;
      logic [31:0] w;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_outs", {rx_if.valid, rx_if.err, rx_if.repeat_out, rx_if.busy}, 0);
      chk("rst_fields", {rx_if.addr, rx_if.cmd, rx_if.rx_status}, 0);
      chk("rst_data", rx_if.data, 0);
      rst_n = 1'b1;
      hold(1'b1, 20);

      // 1: reference frame with strobe latency measured from the stop-mark rising edge
      v0 = n_valid; e0 = n_err;
      w = nec_word(8'h5A, 8'h3C);
      send_frame(w);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         lat[k] = rx_if.valid;
      end
      chk("t1_latency", lat, 6'b001000);
      hold(1'b1, 300);
      chk("t1_valid", n_valid - v0, 1);
      chk("t1_err", n_err - e0, 0);
      chk("t1_addr", rx_if.addr, 8'h5A);
      chk("t1_cmd", rx_if.cmd, 8'h3C);
      chk("t1_data", rx_if.data, 32'hC33CA55A);
      exp_addr = 8'h5A; exp_cmd = 8'h3C; exp_data = 32'hC33CA55A;

      // 2: bit 16 flipped -> checksum error, fields held
      frame_test("t2", 32'hC33CA55A ^ 32'h0001_0000);

      // Randomized frames, some with a single corrupted bit
      for (int i = 0; i < 4; i++) begin
         w = nec_word(8'($urandom), 8'($urandom));
         if ($urandom_range(0, 2) == 0) w = w ^ (32'd1 << $urandom_range(0, 31));
         frame_test("rnd", w);
      end

      // 3: short low glitch is dropped silently
      v0 = n_valid; e0 = n_err;
      hold(1'b0, 40);
      chk("t3_in_lead", rx_if.rx_status, 1);
      hold(1'b0, 10);
      hold(1'b1, 1500);
      chk("t3_valid", n_valid - v0, 0);
      chk("t3_err", n_err - e0, 0);
      chk("t3_busy", rx_if.busy, 0);

      // Overlong leader mark -> err and wait for the line to go high
      e0 = n_err;
      hold(1'b0, 600);
      chk("lm_long_state", rx_if.rx_status, 6);
      chk("lm_long_err", n_err - e0, 1);
      hold(1'b1, 20);
      chk("lm_long_idle", rx_if.rx_status, 0);

      // 4: good frame followed by an NEC repeat frame
      frame_test("t4f", nec_word(8'($urandom), 8'($urandom)));
      e0 = n_err; r0 = n_rep;
      send_repeat();
      hold(1'b1, 300);
`ifdef IR_RX_REPEAT_EN
      chk("t4_rep", n_rep - r0, 1);
      chk("t4_err", n_err - e0, 0);
`else
      chk("t4_rep", n_rep - r0, 0);
      chk("t4_err", n_err - e0, 1);
`endif
      chk("t4_addr", rx_if.addr, exp_addr);
      chk("t4_cmd", rx_if.cmd, exp_cmd);

      // 5: reset after 16 bits aborts the frame
      v0 = n_valid; e0 = n_err; r0 = n_rep;
      send_bits(nec_word(8'($urandom), 8'($urandom)), 16);
      hold(1'b0, 20);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t5_rst_outs", {rx_if.valid, rx_if.err, rx_if.repeat_out, rx_if.busy}, 0);
      chk("t5_rst_fields", {rx_if.addr, rx_if.cmd, rx_if.rx_status}, 0);
      chk("t5_rst_data", rx_if.data, 0);
      exp_addr = '0; exp_cmd = '0; exp_data = '0;
      hold(1'b0, 10);
      hold(1'b1, 300);
      chk("t5_no_strobe", (n_valid - v0) + (n_err - e0) + (n_rep - r0), 0);
      // A repeat with no good frame since reset is always an error
      e0 = n_err; r0 = n_rep;
      send_repeat();
      hold(1'b1, 300);
      chk("t5_rep_norx", n_rep - r0, 0);
      chk("t5_err_norx", n_err - e0, 1);
      frame_test("t5", nec_word(8'h01, 8'hFE));
      chk("t5_data_const", rx_if.data, 32'h01FEFE01);

      // 6: bit space held 3 ms -> timeout err, back to IDLE
      frame_test("t6pre", nec_word(8'($urandom), 8'($urandom)));
      v0 = n_valid; e0 = n_err;
      send_bits(nec_word(8'($urandom), 8'($urandom)), 10);
      hold(1'b0, 28);
      hold(1'b1, 150);
      chk("t6_err", n_err - e0, 1);
      chk("t6_valid", n_valid - v0, 0);
      chk("t6_state", rx_if.rx_status, 0);
      chk("t6_busy", rx_if.busy, 0);
      chk("t6_addr", rx_if.addr, exp_addr);

      chk("strobe_shape", {bad_overlap, bad_width}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
